// File: rtl/mips_pkg.sv
// Shared EX-stage types: mult/div opcodes, iterative mult/div FSM states and
// small opcode decode helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative mult/div datapath: shift-add multiply step or,
// when MULDIV_DIV_EN is defined, one restoring-division step selected by div_mode.
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] oper,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum_s;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] diff_s;
    logic             fits_s;
`endif

    // Multiply: add multiplicand on the low product bit, then shift the pair right.
    // Divide: shift the next dividend bit into the remainder and subtract if it fits.
    always_comb begin
        sum_s = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? oper : {WIDTH{1'b0}})};
`ifdef MULDIV_DIV_EN
        rem_sh_s = {acc_hi, acc_lo[WIDTH-1]};
        fits_s   = (rem_sh_s >= {1'b0, oper});
        // When the divisor fits, the true difference is below 2^WIDTH.
        diff_s   = rem_sh_s[WIDTH-1:0] - oper;
        if (div_mode) begin
            if (fits_s) begin
                hi_nxt = diff_s;
                lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = rem_sh_s[WIDTH-1:0];
                lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_nxt, lo_nxt} = {sum_s, acc_lo[WIDTH-1:1]};
        end
`else
        {hi_nxt, lo_nxt} = {sum_s, acc_lo[WIDTH-1:1]};
`endif
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning HI/LO. Define MULDIV_DIV_EN to
// build the divider; without it DIV/DIVU complete in one cycle leaving HI/LO as is.
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rd_hilo,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   oper_q, oper_d;
    logic               neg_a_q, neg_a_d;
    logic               is_div_q, is_div_d;
`ifdef MULDIV_DIV_EN
    logic               neg_r_q, neg_r_d;
`endif
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    md_op_e             op_s;
    logic               rs_neg_s, rt_neg_s;
    logic [WIDTH-1:0]   rs_mag_s, rt_mag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   step_hi_s, step_lo_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .div_mode (state_q == ST_DIV),
`endif
        .acc_hi   (acc_hi_q),
        .acc_lo   (acc_lo_q),
        .oper     (oper_q),
        .hi_nxt   (step_hi_s),
        .lo_nxt   (step_lo_s)
    );

    // Operand magnitudes at issue and the sign-corrected product at FIX.
    always_comb begin
        op_s     = md_op_e'(op);
        rs_neg_s = is_signed_op(op_s) & rs_val[WIDTH-1];
        rt_neg_s = is_signed_op(op_s) & rt_val[WIDTH-1];
        rs_mag_s = rs_neg_s ? -rs_val : rs_val;
        rt_mag_s = rt_neg_s ? -rt_val : rt_val;
        prod_s   = neg_a_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    end

    // Next-state logic for the FSM, iteration datapath and HI/LO.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        oper_d   = oper_q;
        neg_a_d  = neg_a_q;
        is_div_d = is_div_q;
`ifdef MULDIV_DIV_EN
        neg_r_d  = neg_r_q;
`endif
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                else       hi_d = hi_q;
                if (lo_we) lo_d = wdata;
                else       lo_d = lo_q;

                if (start && !flush) begin
                    cnt_d    = {CW{1'b0}};
                    is_div_d = is_div_op(op_s);
                    if (!is_div_op(op_s)) begin
                        acc_hi_d = {WIDTH{1'b0}};
                        acc_lo_d = rt_mag_s;
                        oper_d   = rs_mag_s;
                        neg_a_d  = rs_neg_s ^ rt_neg_s;
                        state_d  = ST_MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (rt_val == {WIDTH{1'b0}}) begin
                            // Divide by zero: FIX emits these unchanged.
                            acc_hi_d = rs_val;
                            acc_lo_d = {WIDTH{1'b1}};
                            neg_a_d  = 1'b0;
                            neg_r_d  = 1'b0;
                            state_d  = ST_FIX;
                        end else begin
                            acc_hi_d = {WIDTH{1'b0}};
                            acc_lo_d = rs_mag_s;
                            oper_d   = rt_mag_s;
                            neg_a_d  = rs_neg_s ^ rt_neg_s;
                            neg_r_d  = rs_neg_s;
                            state_d  = ST_DIV;
                        end
`else
                        state_d = ST_FIX;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi_s;
                    acc_lo_d = step_lo_s;
                    cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) state_d = ST_FIX;
                    else                   state_d = ST_MUL;
                end
            end

`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi_s;
                    acc_lo_d = step_lo_s;
                    cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) state_d = ST_FIX;
                    else                   state_d = ST_DIV;
                end
            end
`endif

            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (is_div_q) begin
`ifdef MULDIV_DIV_EN
                        hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
                        lo_d = neg_a_q ? -acc_lo_q : acc_lo_q;
`else
                        hi_d = hi_q;
                        lo_d = lo_q;
`endif
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            oper_q   <= {WIDTH{1'b0}};
            neg_a_q  <= 1'b0;
            is_div_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_r_q  <= 1'b0;
`endif
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            oper_q   <= oper_d;
            neg_a_q  <= neg_a_d;
            is_div_q <= is_div_d;
`ifdef MULDIV_DIV_EN
            neg_r_q  <= neg_r_d;
`endif
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (start | rd_hilo | hi_we | lo_we);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus random ops compared
// against an arithmetic reference model; follows MULDIV_DIV_EN if defined.
module tb_ex_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         rd_hilo = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         flush = 1'b0;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .rd_hilo (rd_hilo),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Architectural result {hi, lo} of one op given the current {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
`ifdef MULDIV_DIV_EN
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            2'b11: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
`endif
            default: return cur;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b);
        if (o[1] == 1'b0) return W + 1;
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return 1;
        return W + 1;
`else
        return (b == b) ? 1 : 1;
`endif
    endfunction

    // Called at the negedge after the issue edge; returns busy cycles seen.
    task automatic wait_done(output int cycles, output int stall_cnt);
        cycles = 0;
        stall_cnt = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (stall === 1'b1) stall_cnt++;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic watch);
        logic [63:0] exp_v;
        int          lat, cyc, stc;
        exp_v = ref_result(o, a, b, {exp_hi, exp_lo});
        lat   = ref_latency(o, b);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b; rd_hilo = watch;
        @(negedge clk);
        check("stall_idle", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_issue", {63'd0, busy}, 64'd1);
        wait_done(cyc, stc);
        check("latency", 64'(cyc), 64'(lat));
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("hilo", {hi, lo}, exp_v);
        if (watch) begin
            check("stall_window", 64'(stc), 64'(lat));
            check("stall_at_done", {63'd0, stall}, 64'd0);
        end
        rd_hilo = 1'b0;
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        {exp_hi, exp_lo} = exp_v;
    endtask

    initial begin
        int          cyc, stc, dn;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [1:0]  rst_op;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // MTLO / MTHI in IDLE
        @(posedge clk); #1;
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0000_CAFE;
        @(negedge clk);
        check("mt_idle_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        lo_we = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        check("mt_idle_hilo", {hi, lo}, 64'h0000_CAFE_0000_CAFE);
        exp_hi = 32'h0000_CAFE; exp_lo = 32'h0000_CAFE;

        // Directed arithmetic
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
        check("mult_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b10, 32'd5, 32'd0, 1'b1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Flush at cycle 10 of a MULT
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; rs_val = 32'd12345; rt_val = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", {63'd0, busy}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("flush_no_done", 64'(dn), 64'd0);
        check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});

        // start together with flush is ignored
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("sflush_busy", {63'd0, busy}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("sflush_no_done", 64'(dn), 64'd0);
        check("sflush_hilo", {hi, lo}, {exp_hi, exp_lo});

        // MTHI while busy stalls and is held off until IDLE
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; rs_val = 32'd6; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        check("mthi_busy_stall", {63'd0, stall}, 64'd1);
        check("mthi_busy_hi", {32'd0, hi}, {32'd0, exp_hi});
        wait_done(cyc, stc);
        check("mthi_latency", 64'(cyc), 64'(W + 1));
        check("mthi_stall_window", 64'(stc), 64'(W + 1));
        check("mthi_result", {hi, lo}, 64'd42);
        check("mthi_stall_done", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        hi_we = 1'b0;
        @(negedge clk);
        check("mthi_after_idle", {hi, lo}, {32'h0000_1234, 32'd42});
        exp_hi = 32'h0000_1234; exp_lo = 32'd42;

        // Random ops against the reference model
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = 32'd0;
            if (i % 3 == 1) rb = $urandom_range(1, 20);
            run_op(ro, ra, rb, 1'(i % 2));
        end

        // Async reset mid-operation
`ifdef MULDIV_DIV_EN
        rst_op = 2'b10;
`else
        rst_op = 2'b00;
`endif
        @(posedge clk); #1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_0001;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = rst_op; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        run_op(2'b01, 32'd9, 32'd9, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
